shift_scaler: RTL and testbench

- Parametrised, pipelined barrel shifter and fixed-point scaler for the neural-network datapath.
- Sits between the MAC/accumulator outputs and the activation stage. Rescales accumulated values by a power of two.
- Adds logical, arithmetic, rotate, saturating and rounding modes, plus a valid/ready handshake with backpressure and a saturation event counter.

---
 rtl/shift_scaler.sv | 194 +++++++++++++++++++
 tb/tb_shift_scaler.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_scaler.sv
// shift_scaler: pipelined barrel shifter and power-of-two fixed-point scaler.
// Every mode is recast up front as a single left or right shift of a
// double-width working word. The log2 levels of that shift are spread over
// the pipeline stages, and the last stage formats the result and detects
// saturation. A single global stall freezes the whole pipe under backpressure.
module shift_scaler #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 8,
    parameter int STAGES  = 2,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [2:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_sat,
    input  logic               clr_stats,
    output logic [CNT_W-1:0]   sat_count
);

    // Effective shift amounts are clamped to 0..WIDTH, so this many levels suffice.
    localparam int LVLS = $clog2(WIDTH + 1);
    localparam int WW   = 2 * WIDTH;

    typedef enum logic [2:0] {
        MODE_SLL  = 3'd0,
        MODE_SRL  = 3'd1,
        MODE_SRA  = 3'd2,
        MODE_ROL  = 3'd3,
        MODE_ROR  = 3'd4,
        MODE_SATL = 3'd5,
        MODE_RND  = 3'd6,
        MODE_RSVD = 3'd7
    } mode_e;

    // One pipeline slot: the working word, the shift amount it still has to
    // apply, its direction, and the context needed to format the result.
    typedef struct packed {
        logic             valid;
        logic             left;
        logic             satMode;
        logic             sign;
        logic [LVLS-1:0]  amt;
        logic [WW-1:0]    word;
        logic [WIDTH-1:0] res;
        logic             sat;
    } stage_t;

    stage_t           entry;
    stage_t           pipeD [STAGES];
    stage_t           pipeQ [STAGES];
    logic [31:0]      shamtWide;
    logic [31:0]      rotAmt;
    logic [WIDTH:0]   rndSum;
    logic             bigShift;
    logic             stall;
    logic [CNT_W-1:0] satCount_q;
    logic [CNT_W-1:0] satCount_d;

    // First barrel level handled by stage k; stage k covers [levelLo(k), levelLo(k+1)).
    function automatic int levelLo(input int k);
        return (k * LVLS) / STAGES;
    endfunction

    assign stall     = pipeQ[STAGES-1].valid & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = pipeQ[STAGES-1].valid;
    assign out_data  = pipeQ[STAGES-1].res;
    assign out_sat   = pipeQ[STAGES-1].sat;
    assign sat_count = satCount_q;

    // Recast the requested mode as a plain shift of a 2*WIDTH word: right
    // shifts keep the result in the low half with the fill (zero, sign or a
    // copy of the data for rotates) in the high half; left shifts keep a
    // sign-extended copy so bits pushed past the result width stay visible.
    always_comb begin
        shamtWide = 32'(in_shamt);
        bigShift  = (shamtWide >= 32'(WIDTH));
        rotAmt    = shamtWide % 32'(WIDTH);
        rndSum    = {in_data[WIDTH-1], in_data};
        if (!bigShift && (shamtWide != 32'd0)) begin
            rndSum = rndSum + ((WIDTH+1)'(1) << (shamtWide - 32'd1));
        end
        entry         = '0;
        entry.valid   = in_valid;
        entry.sign    = in_data[WIDTH-1];
        entry.amt     = bigShift ? LVLS'(WIDTH) : LVLS'(shamtWide);
        case (mode_e'(in_mode))
            MODE_SLL: begin
                entry.left = 1'b1;
                entry.word = {{WIDTH{1'b0}}, in_data};
            end
            MODE_SRL: begin
                entry.word = {{WIDTH{1'b0}}, in_data};
            end
            MODE_SRA: begin
                entry.word = {{WIDTH{in_data[WIDTH-1]}}, in_data};
            end
            MODE_ROL: begin
                entry.word = {in_data, in_data};
                entry.amt  = (rotAmt == 32'd0) ? '0 : LVLS'(32'(WIDTH) - rotAmt);
            end
            MODE_ROR: begin
                entry.word = {in_data, in_data};
                entry.amt  = LVLS'(rotAmt);
            end
            MODE_SATL: begin
                entry.left    = 1'b1;
                entry.satMode = 1'b1;
                entry.word    = {{WIDTH{in_data[WIDTH-1]}}, in_data};
            end
            MODE_RND: begin
                if (bigShift) begin
                    entry.word = '0;
                    entry.amt  = '0;
                end else begin
                    entry.word = {{(WIDTH-1){rndSum[WIDTH]}}, rndSum};
                end
            end
            default: begin
                entry.word = '0;
                entry.amt  = '0;
            end
        endcase
    end

    // Each stage applies its share of the barrel levels; the last stage also
    // decides saturation and produces the final result and sat flag.
    always_comb begin
        stage_t cur;
        logic   ovf;
        for (int k = 0; k < STAGES; k++) begin
            ovf = 1'b0;
            cur = (k == 0) ? entry : pipeQ[(k == 0) ? 0 : k - 1];
            for (int lvl = 0; lvl < LVLS; lvl++) begin
                if ((lvl >= levelLo(k)) && (lvl < levelLo(k + 1)) && cur.amt[lvl]) begin
                    cur.word = cur.left ? (cur.word << (1 << lvl)) : (cur.word >> (1 << lvl));
                end
            end
            cur.res = '0;
            cur.sat = 1'b0;
            if (k == STAGES - 1) begin
                ovf = cur.satMode &&
                      (cur.sign ? ~&cur.word[WW-1:WIDTH-1] : |cur.word[WW-1:WIDTH-1]);
                if (ovf) begin
                    cur.res = cur.sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                    cur.sat = 1'b1;
                end else begin
                    cur.res = cur.word[WIDTH-1:0];
                end
            end
            pipeD[k] = cur;
        end
    end

    // Advance every stage together unless the output is blocked downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                pipeQ[k] <= '0;
            end
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                pipeQ[k] <= pipeD[k];
            end
        end
    end

    // Next saturation count: clear wins, otherwise count delivered clamps and stick at all-ones.
    always_comb begin
        satCount_d = satCount_q;
        if (clr_stats) begin
            satCount_d = '0;
        end else if (out_valid && out_ready && out_sat && !(&satCount_q)) begin
            satCount_d = satCount_q + CNT_W'(1);
        end
    end

    // Saturation event counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            satCount_q <= '0;
        end else begin
            satCount_q <= satCount_d;
        end
    end

endmodule

// File: tb/tb_shift_scaler.sv
// tb_shift_scaler: directed and randomized checks of shift_scaler against an
// arithmetic reference model, including backpressure, async reset and stats.
module tb_shift_scaler;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 8;
    localparam int STAGES  = 2;
    localparam int CNT_W   = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [2:0]         in_mode;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_sat;
    logic               clr_stats;
    logic [CNT_W-1:0]   sat_count;

    typedef struct packed {
        logic [31:0] res;
        logic        sat;
    } exp_t;

    exp_t expQ[$];
    int   checks    = 0;
    int   failures  = 0;
    int   delivered = 0;
    int   cycle     = 0;

    shift_scaler #(
        .WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .STAGES(STAGES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat),
        .clr_stats(clr_stats), .sat_count(sat_count)
    );

    // Free-running clock and a cycle counter for throughput measurement.
    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    // Reference model: the specified results computed with plain integer arithmetic.
    function automatic exp_t model(input logic [31:0] d, input logic [7:0] s, input logic [2:0] m);
        exp_t        r;
        longint      sd;
        longint      p;
        logic [63:0] dd;
        int          sh;
        r  = '0;
        sd = longint'($signed(d));
        dd = {d, d};
        sh = int'(s);
        case (m)
            3'd0: r.res = (sh >= 32) ? 32'd0 : (d << sh);
            3'd1: r.res = (sh >= 32) ? 32'd0 : (d >> sh);
            3'd2: r.res = (sh >= 32) ? {32{d[31]}} : 32'($signed(d) >>> sh);
            3'd3: r.res = 32'((dd << (sh % 32)) >> 32);
            3'd4: r.res = 32'(dd >> (sh % 32));
            3'd5: begin
                if (d == 32'd0) begin
                    r.res = 32'd0;
                end else if (sh >= 32) begin
                    r.res = d[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    r.sat = 1'b1;
                end else begin
                    p = sd * (longint'(1) << sh);
                    if (p > longint'(32'h7FFF_FFFF)) begin
                        r.res = 32'h7FFF_FFFF;
                        r.sat = 1'b1;
                    end else if (p < -longint'(64'h8000_0000)) begin
                        r.res = 32'h8000_0000;
                        r.sat = 1'b1;
                    end else begin
                        r.res = 32'(p);
                    end
                end
            end
            3'd6: begin
                if (sh == 0)       r.res = d;
                else if (sh >= 32) r.res = 32'd0;
                else               r.res = 32'((sd + (longint'(1) << (sh - 1))) >>> sh);
            end
            default: r.res = 32'd0;
        endcase
        return r;
    endfunction

    // One comparison: counts it, and reports tag/observed/expected on a miss.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present one operand (called just after a rising edge) and return just
    // after the edge that accepted it.
    task automatic applyStimulus(input logic [31:0] d, input logic [7:0] s, input logic [2:0] m);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
        in_mode  = m;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Single operation with a constant expectation and an exact latency check.
    task automatic runDirected(input string tag, input logic [31:0] d, input logic [7:0] s,
                               input logic [2:0] m, input logic [31:0] expRes, input logic expSat);
        applyStimulus(d, s, m);
        @(negedge clk);
        checkOutput({tag, "_early"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput(tag, out_data, expRes);
        checkOutput({tag, "_sat"}, 32'(out_sat), 32'(expSat));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] randData();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 255));
            1:       return -32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [7:0] randShamt();
        if ($urandom_range(0, 7) == 0) return 8'($urandom);
        return 8'($urandom_range(0, 33));
    endfunction

    // Scoreboard: record accepted operands, compare every delivered result in order.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (in_valid && in_ready) begin
                expQ.push_back(model(in_data, in_shamt, in_mode));
            end
            if (out_valid && out_ready) begin
                checkOutput("sb_nonempty", 32'(expQ.size() != 0), 32'd1);
                if (expQ.size() != 0) begin
                    e = expQ.pop_front();
                    checkOutput("sb_data", out_data, e.res);
                    checkOutput("sb_sat", 32'(out_sat), 32'(e.sat));
                    delivered++;
                end
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequence followed by a randomized backpressure run.
    initial begin
        int  c0;
        int  d0;
        int  n;
        bit  pending;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_mode   = '0;
        out_ready = 1'b1;
        clr_stats = 1'b0;
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", out_data, 32'd0);
        checkOutput("rst_sat_count", 32'(sat_count), 32'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic latency, then a back-to-back burst at full throughput.
        runDirected("sll_f0", 32'h0000_00F0, 8'd4, 3'd0, 32'h0000_0F00, 1'b0);
        c0 = cycle;
        d0 = delivered;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(randData(), randShamt(), 3'($urandom_range(0, 7)));
        end
        checkOutput("burst_cycles", 32'(cycle - c0), 32'd10);
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("burst_delivered", 32'(delivered - d0), 32'd10);
        checkOutput("burst_drained", 32'(expQ.size()), 32'd0);
        @(posedge clk);
        #1;

        // Shift and rotate boundaries.
        runDirected("sra_31", 32'h8000_0000, 8'd31, 3'd2, 32'hFFFF_FFFF, 1'b0);
        runDirected("sra_40", 32'h8000_0000, 8'd40, 3'd2, 32'hFFFF_FFFF, 1'b0);
        runDirected("srl_40", 32'h8000_0000, 8'd40, 3'd1, 32'h0000_0000, 1'b0);
        runDirected("ror_1", 32'h0000_0001, 8'd1, 3'd4, 32'h8000_0000, 1'b0);
        runDirected("rol_33", 32'h0000_0001, 8'd33, 3'd3, 32'h0000_0002, 1'b0);

        // Saturating left shift and its event count.
        clr_stats = 1'b1;
        @(posedge clk);
        #1;
        clr_stats = 1'b0;
        checkOutput("clr_count", 32'(sat_count), 32'd0);
        runDirected("satl_pos", 32'h4000_0000, 8'd1, 3'd5, 32'h7FFF_FFFF, 1'b1);
        runDirected("satl_neg_ok", 32'hC000_0000, 8'd1, 3'd5, 32'h8000_0000, 1'b0);
        runDirected("satl_neg", 32'hBFFF_FFFF, 8'd1, 3'd5, 32'h8000_0000, 1'b1);
        runDirected("satl_zero", 32'h0000_0000, 8'd50, 3'd5, 32'h0000_0000, 1'b0);
        checkOutput("satl_count", 32'(sat_count), 32'd2);

        // Rounding shift.
        runDirected("rnd_7", 32'h0000_0007, 8'd1, 3'd6, 32'h0000_0004, 1'b0);
        runDirected("rnd_m5", 32'hFFFF_FFFB, 8'd1, 3'd6, 32'hFFFF_FFFE, 1'b0);
        runDirected("rnd_32", 32'h7FFF_FFFF, 8'd32, 3'd6, 32'h0000_0000, 1'b0);
        runDirected("rnd_0", 32'h1234_5678, 8'd0, 3'd6, 32'h1234_5678, 1'b0);
        runDirected("rsvd", 32'hDEAD_BEEF, 8'd3, 3'd7, 32'h0000_0000, 1'b0);

        // Backpressure: A and B enter, C waits until the output is released.
        out_ready = 1'b0;
        applyStimulus(32'h0000_0011, 8'd1, 3'd0);
        applyStimulus(32'h0000_0022, 8'd1, 3'd0);
        in_valid = 1'b1;
        in_data  = 32'h0000_0033;
        in_shamt = 8'd1;
        in_mode  = 3'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_hold_data", out_data, 32'h0000_0022);
            checkOutput("bp_in_ready", 32'(in_ready), (i < 4) ? 32'd0 : 32'd1);
            @(posedge clk);
            #1;
            if (i == 3) out_ready = 1'b1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("bp_b_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_b_data", out_data, 32'h0000_0044);
        @(negedge clk);
        checkOutput("bp_c_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_c_data", out_data, 32'h0000_0066);
        @(posedge clk);
        #1;

        // Async reset with items in flight and a non-zero count.
        clr_stats = 1'b1;
        @(posedge clk);
        #1;
        clr_stats = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(32'h4000_0000, 8'd1, 3'd5);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("pre_reset_count", 32'(sat_count), 32'd3);
        applyStimulus(32'h0000_0005, 8'd2, 3'd0);
        applyStimulus(32'h4000_0000, 8'd2, 3'd5);
        checkOutput("pre_reset_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        expQ.delete();
        checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("async_rst_count", 32'(sat_count), 32'd0);
        checkOutput("async_rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_stale", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        runDirected("post_rst", 32'h0000_0009, 8'd3, 3'd1, 32'h0000_0001, 1'b0);

        // Clear arriving together with a saturating delivery.
        runDirected("cnt_one", 32'h4000_0000, 8'd1, 3'd5, 32'h7FFF_FFFF, 1'b1);
        checkOutput("cnt_one_count", 32'(sat_count), 32'd1);
        applyStimulus(32'h8000_0001, 8'd4, 3'd5);
        @(posedge clk);
        #1;
        clr_stats = 1'b1;
        @(negedge clk);
        checkOutput("coinc_sat", 32'(out_valid & out_sat), 32'd1);
        @(posedge clk);
        #1;
        clr_stats = 1'b0;
        checkOutput("coinc_count", 32'(sat_count), 32'd0);

        // Randomized traffic with random backpressure; operands held until accepted.
        pending = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!pending) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = randData();
                in_shamt = randShamt();
                in_mode  = 3'($urandom_range(0, 7));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            pending = in_valid && !in_ready;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (expQ.size() != 0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("rand_drained", 32'(expQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
